dsram_arb: RTL and testbench
============================

# dsram_arb

Two-requester arbiter for the single-port data SRAM. It sits between the core load/store port and the 32-bit byte-enabled data SRAM and shares that SRAM with a host loader/debug port. The core has priority, and a starvation counter guarantees the host a slot. Read data is routed back to the requester that issued the read, one cycle later.

## Interface
- AW, 16: byte-address width of both request ports and of the SRAM side.
- MAX_HOLD, 4: number of consecutive contested cycles the core may win before the host is owed a turn. Legal range 1..15.

Ports (clock and reset first):
- clk  in  1  Single clock; all state updates on its rising edge.
- rst  in  1  Reset; synchronous, active-high.
- c_a  in  AW  Core byte address.
- c_we  in  4  Core byte write enables.
- c_wd  in  32  Core write data.
- c_re  in  4  Core byte read enables. The core requests when `c_we|c_re != 0`.
- c_stall  out  1  Core request was not accepted this cycle. The core holds all c_* fields stable.
- c_rd  out  32  Core read data.
- c_rvld  out  1  c_rd is valid for a core read accepted last cycle.
- h_req  in  1  Host request.
- h_a  in  AW  Host byte address.
- h_we  in  4  Host byte write enables.
- h_wd  in  32  Host write data.
- h_re  in  4  Host byte read enables.
- h_gnt  out  1  Host request accepted this cycle.
- h_rd  out  32  Host read data.
- h_rvld  out  1  h_rd is valid for a host read accepted last cycle.
- m_a  out  AW  SRAM byte address. The SRAM registers it and uses word address `m_a[AW-1:2]`.
- m_we  out  4  SRAM byte write enables.
- m_wd  out  32  SRAM write data.
- m_re  out  4  SRAM byte read enables.
- m_rd  in  32  SRAM read data, valid the cycle after the access is presented.

## Operation
- Requests:
  - creq = `|c_we | |c_re`.
  - hreq = h_req.
  - Exactly one requester is selected per cycle. m_* carries the winner's fields.
  - With no requester: m_we=0, m_re=0, and m_a/m_wd are don't-care.
- State machine, two states:
  - CORE_PRI:
    - Core wins whenever creq=1.
    - Host wins only when hreq=1 and creq=0.
    - A contested cycle (creq & hreq) won by the core increments cstreak.
    - When the increment makes cstreak==MAX_HOLD, go to HOST_TURN and clear cstreak.
    - An uncontested cycle clears cstreak.
  - HOST_TURN:
    - Host wins whenever hreq=1, even if creq=1. Then return to CORE_PRI.
    - If hreq=0, the core wins if it requests, and the block returns to CORE_PRI.
- Outputs:
  - c_stall = creq & host won.
  - h_gnt = hreq & host won.
  - A host request not granted stays pending. The host holds h_* until h_gnt.
- Read routing:
  - Register rsel_c = (core won & |c_re) and rsel_h = (host won & |h_re).
  - Next cycle: c_rvld=rsel_c, h_rvld=rsel_h.
  - c_rd and h_rd both pass m_rd through. Data is meaningful only with its rvld.
- Width: cstreak is 4 bits. Addresses pass through unmodified.
- Write-then-read to the same word by different requesters in consecutive cycles: the SRAM's ordering holds. The arbiter does no forwarding.

## Timing
- Arbitration is combinational in the request cycle: c_stall, h_gnt and m_* settle in the same cycle as the request.
- Read latency: access presented in cycle N; rvld=1 and data valid in cycle N+1.
- Back-to-back accepts are allowed every cycle. Full throughput: one access per cycle.
- Reset values:
  - State CORE_PRI, cstreak=0, rsel_c=0, rsel_h=0.
  - c_rvld=0, h_rvld=0, c_stall=0, h_gnt=0.
- While rst=1, m_we=0 and m_re=0 are forced regardless of inputs.
- Reset asserted mid-read: the pending rvld for that read is dropped in the cycle after reset.
- The worst-case host wait under continuous core traffic is MAX_HOLD+1 cycles.

## Test plan
- Core only: c_we=4'hF, c_a=0x0010, c_wd=0xDEADBEEF. Then c_re=4'hF at the same address. Required: c_stall=0 throughout; c_rvld=1 one cycle after the read; c_rd=0xDEADBEEF; h_gnt=0.
- Host only:
  - h_req=1, h_we=4'h3, h_a=0x0020, h_wd=0x0000ABCD. Required: h_gnt=1 in the same cycle.
  - Then a host read at 0x0020. Required: h_rvld=1 next cycle, h_rd[15:0]=0xABCD, c_rvld=0.
- Continuous contention, MAX_HOLD=4: creq and hreq both high every cycle. Required:
  - The core wins cycles 1–4.
  - The host wins cycle 5, with c_stall=1 and h_gnt=1.
  - The pattern repeats with period 5.
- HOST_TURN with the host absent: reach HOST_TURN, then drop h_req for one cycle while the core requests. Required: the core wins (c_stall=0), the state returns to CORE_PRI, and cstreak=0.
- Read routing across the switch: a core read in cycle N and a host read (host wins) in cycle N+1. Required: c_rvld=1 only in N+1, h_rvld=1 only in N+2, and the correct m_rd appears in each.
- Reset mid-operation: assert rst in the cycle a host read is accepted. Required: m_re=0 while rst=1, h_rvld=0 the next cycle, and all outputs at their reset values.

Source files
------------

// File: rtl/dsram_arb_if.sv
// dsram_arb_if: core, host and SRAM-side signals of the data SRAM arbiter
interface dsram_arb_if #(parameter int AW = 16);
  logic [AW-1:0] c_a;
  logic [3:0]    c_we;
  logic [31:0]   c_wd;
  logic [3:0]    c_re;
  logic          c_stall;
  logic [31:0]   c_rd;
  logic          c_rvld;
  logic          h_req;
  logic [AW-1:0] h_a;
  logic [3:0]    h_we;
  logic [31:0]   h_wd;
  logic [3:0]    h_re;
  logic          h_gnt;
  logic [31:0]   h_rd;
  logic          h_rvld;
  logic [AW-1:0] m_a;
  logic [3:0]    m_we;
  logic [31:0]   m_wd;
  logic [3:0]    m_re;
  logic [31:0]   m_rd;
  modport slave (
    input  c_a, c_we, c_wd, c_re, h_req, h_a, h_we, h_wd, h_re, m_rd,
    output c_stall, c_rd, c_rvld, h_gnt, h_rd, h_rvld, m_a, m_we, m_wd, m_re
  );
  modport master (
    output c_a, c_we, c_wd, c_re, h_req, h_a, h_we, h_wd, h_re, m_rd,
    input  c_stall, c_rd, c_rvld, h_gnt, h_rd, h_rvld, m_a, m_we, m_wd, m_re
  );
endinterface

// File: rtl/dsram_arb.sv
// dsram_arb: core-priority arbiter with a host starvation guard for the shared data SRAM
module dsram_arb #(
  parameter int AW       = 16,
  parameter int MAX_HOLD = 4
) (
  input logic        clk,
  input logic        rst,
  dsram_arb_if.slave bus
);
  typedef enum logic {CORE_PRI, HOST_TURN} state_t;
  state_t        state_q, state_d;
  logic [3:0]    cstreak_q, cstreak_d, cinc;
  logic          rsel_c_q, rsel_c_d, rsel_h_q, rsel_h_d;
  logic          creq, hreq, host_win, core_win, hit;
  logic [AW-1:0] a_win;
  always_comb begin
    creq      = |bus.c_we | |bus.c_re;
    hreq      = bus.h_req;
    host_win  = !rst & hreq & (!creq | state_q == HOST_TURN);
    core_win  = !rst & creq & !host_win;
    cinc      = cstreak_q + 4'd1;
    hit       = creq & hreq & cinc == 4'(MAX_HOLD);
    state_d   = state_q;
    cstreak_d = cstreak_q;
    if (state_q == CORE_PRI) begin
      cstreak_d = (creq & hreq & !hit) ? cinc : 4'd0;
      state_d   = hit ? HOST_TURN : CORE_PRI;
    end else if (creq | hreq) begin
      state_d   = CORE_PRI;
    end
    rsel_c_d  = core_win & |bus.c_re;
    rsel_h_d  = host_win & |bus.h_re;
    a_win     = host_win ? bus.h_a : bus.c_a;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CORE_PRI;
      cstreak_q <= 4'd0;
      rsel_c_q  <= 1'b0;
      rsel_h_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cstreak_q <= cstreak_d;
      rsel_c_q  <= rsel_c_d;
      rsel_h_q  <= rsel_h_d;
    end
  end
  assign bus.c_stall = creq & host_win;
  assign bus.h_gnt   = host_win;
  assign bus.c_rd    = bus.m_rd;
  assign bus.h_rd    = bus.m_rd;
  assign bus.c_rvld  = rsel_c_q;
  assign bus.h_rvld  = rsel_h_q;
  assign bus.m_a     = a_win;
  assign bus.m_wd    = host_win ? bus.h_wd : bus.c_wd;
  assign bus.m_we    = host_win ? bus.h_we : core_win ? bus.c_we : 4'd0;
  assign bus.m_re    = host_win ? bus.h_re : core_win ? bus.c_re : 4'd0;
endmodule

// File: tb/tb_dsram_arb.sv
// tb_dsram_arb: randomized scoreboard bench for dsram_arb against a rule-level reference model
module tb_dsram_arb;
  localparam int AW = 16;
  localparam int MH = 4;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  dsram_arb_if #(.AW(AW)) bus();
  dsram_arb #(.AW(AW), .MAX_HOLD(MH)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {int due; logic [31:0] d;} rd_t;
  rd_t cq[$];
  rd_t hq[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int streak = 0;
  logic last_stall = 0;
  logic last_gnt = 0;
  logic [31:0] mem [16384];
  logic [31:0] ref_mem [16384];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", n, cyc, a, e);
    end
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (bus.m_we[b]) mem[bus.m_a[AW-1:2]][8*b +: 8] <= bus.m_wd[8*b +: 8];
    if (|bus.m_re) bus.m_rd <= mem[bus.m_a[AW-1:2]];
  end
  always @(negedge clk) begin : model
    logic creq, hreq, hw, cw;
    logic [AW-1:0] a;
    logic [3:0] we, re;
    logic [31:0] wd;
    rd_t e;
    creq = (bus.c_we != 0) || (bus.c_re != 0);
    hreq = bus.h_req;
    if (rst) begin
      hw = 0;
      cw = 0;
      streak = 0;
    end else begin
      hw = hreq && (!creq || streak == MH);
      cw = creq && !hw;
      if (streak == MH) begin
        if (hreq || creq) streak = 0;
      end else begin
        streak = (creq && hreq) ? streak + 1 : 0;
      end
    end
    a  = hw ? bus.h_a : bus.c_a;
    we = hw ? bus.h_we : cw ? bus.c_we : 4'd0;
    re = hw ? bus.h_re : cw ? bus.c_re : 4'd0;
    wd = hw ? bus.h_wd : bus.c_wd;
    chk("c_stall", 32'(bus.c_stall), 32'(creq && hw));
    chk("h_gnt", 32'(bus.h_gnt), 32'(hw));
    chk("m_we", 32'(bus.m_we), 32'(we));
    chk("m_re", 32'(bus.m_re), 32'(re));
    if (hw || cw) chk("m_a", 32'(bus.m_a), 32'(a));
    if (we != 0) chk("m_wd", bus.m_wd, wd);
    if (re != 0) begin
      e.due = cyc + 1;
      e.d = ref_mem[a[AW-1:2]];
      if (hw) hq.push_back(e);
      else cq.push_back(e);
    end
    for (int b = 0; b < 4; b++)
      if (we[b]) ref_mem[a[AW-1:2]][8*b +: 8] = wd[8*b +: 8];
    last_stall = creq && hw;
    last_gnt = hw;
  end
  always @(negedge clk) begin : monitor
    logic cv, hv;
    if (rst) begin
      while (cq.size() > 0 && cq[0].due <= cyc) void'(cq.pop_front());
      while (hq.size() > 0 && hq[0].due <= cyc) void'(hq.pop_front());
    end else begin
      cv = cq.size() > 0 && cq[0].due == cyc;
      hv = hq.size() > 0 && hq[0].due == cyc;
      chk("c_rvld", 32'(bus.c_rvld), 32'(cv));
      chk("h_rvld", 32'(bus.h_rvld), 32'(hv));
      if (cv) begin
        chk("c_rd", bus.c_rd, cq[0].d);
        void'(cq.pop_front());
      end
      if (hv) begin
        chk("h_rd", bus.h_rd, hq[0].d);
        void'(hq.pop_front());
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic core(input logic [3:0] we, input logic [3:0] re, input logic [15:0] a, input logic [31:0] wd);
    bus.c_we = we;
    bus.c_re = re;
    bus.c_a = a;
    bus.c_wd = wd;
  endtask
  task automatic host(input logic r, input logic [3:0] we, input logic [3:0] re, input logic [15:0] a, input logic [31:0] wd);
    bus.h_req = r;
    bus.h_we = we;
    bus.h_re = re;
    bus.h_a = a;
    bus.h_wd = wd;
  endtask
  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem[i] = 0;
      ref_mem[i] = 0;
    end
    core(0, 0, 0, 0);
    host(0, 0, 0, 0, 0);
    repeat (3) tick();
    @(negedge clk);
    chk("rst_c_rvld", 32'(bus.c_rvld), 0);
    chk("rst_h_rvld", 32'(bus.h_rvld), 0);
    rst = 0;
    tick();
    core(4'hF, 0, 16'h0010, 32'hDEADBEEF);
    tick();
    core(0, 4'hF, 16'h0010, 0);
    tick();
    core(0, 0, 0, 0);
    @(negedge clk);
    chk("core_rd", bus.c_rd, 32'hDEADBEEF);
    tick();
    host(1, 4'h3, 0, 16'h0020, 32'h0000ABCD);
    tick();
    host(1, 0, 4'hF, 16'h0020, 0);
    tick();
    host(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("host_rd", 32'(bus.h_rd[15:0]), 32'h0000ABCD);
    tick();
    core(0, 4'hF, 16'h0040, 0);
    host(1, 0, 4'hF, 16'h0044, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("contend_gnt", 32'(bus.h_gnt), 32'(i % 5 == 4));
      chk("contend_stall", 32'(bus.c_stall), 32'(i % 5 == 4));
      tick();
    end
    core(0, 0, 0, 0);
    host(0, 0, 0, 0, 0);
    tick();
    core(0, 4'hF, 16'h0010, 0);
    host(1, 0, 4'hF, 16'h0020, 0);
    repeat (4) tick();
    host(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("absent_stall", 32'(bus.c_stall), 0);
    tick();
    host(1, 0, 4'hF, 16'h0020, 0);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("absent_restart", 32'(bus.h_gnt), 32'(j == 4));
      tick();
    end
    core(0, 0, 0, 0);
    host(0, 0, 0, 0, 0);
    tick();
    core(0, 4'hF, 16'h0010, 0);
    tick();
    core(0, 0, 0, 0);
    host(1, 0, 4'hF, 16'h0020, 0);
    tick();
    host(0, 0, 0, 0, 0);
    tick();
    host(1, 0, 4'hF, 16'h0020, 0);
    tick();
    rst = 1;
    @(negedge clk);
    chk("rst_m_re", 32'(bus.m_re), 0);
    tick();
    rst = 0;
    host(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("post_rst_h_rvld", 32'(bus.h_rvld), 0);
    chk("post_rst_c_stall", 32'(bus.c_stall), 0);
    tick();
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] ca, ha;
      ca = {10'd0, 4'($urandom_range(15)), 2'($urandom_range(3))};
      ha = {10'd0, 4'($urandom_range(15)), 2'($urandom_range(3))};
      if (!last_stall || rst) begin
        case ($urandom_range(3))
          0: core(0, 0, ca, 0);
          1: core(4'($urandom_range(1, 15)), 0, ca, $urandom);
          default: core(0, 4'($urandom_range(1, 15)), ca, 0);
        endcase
      end
      if (!bus.h_req || last_gnt) begin
        case ($urandom_range(3))
          0: host(0, 0, 0, ha, 0);
          1: host(1, 4'($urandom_range(1, 15)), 0, ha, $urandom);
          default: host(1, 0, 4'($urandom_range(1, 15)), ha, 0);
        endcase
      end
      rst = ($urandom_range(99) == 0);
      tick();
    end
    rst = 0;
    core(0, 0, 0, 0);
    host(0, 0, 0, 0, 0);
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
